pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the processor's fetch stage. It holds the instruction address and advances it by one, loads absolute jump targets, and supports subroutine call/return through an internal return-address stack. It replaces the single-width, edge-driven PC with a fully synchronous, clock-enabled design.

## Interface

Parameters:
- WIDTH, 11, PC/address width in bits.
- STACK_DEPTH, 4, number of return-address entries (≥1).
- RESET_VECTOR, 0, value loaded into Q on reset (WIDTH bits).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- increment  input  1  advance Q by one this cycle.
- load  input  1  Q <= D this cycle.
- D  input  WIDTH  jump/call target.
- call  input  1  push return address, Q <= D.
- ret  input  1  pop return address into Q.
- Q  output  WIDTH  current PC (registered).
- stack_empty  output  1  no entries on stack.
- stack_full  output  1  STACK_DEPTH entries on stack.
- stack_err  output  1  sticky overflow/underflow flag.

## Operation

- One action per cycle, fixed priority: reset > ret > call > load > increment > hold.
- hold: no control asserted; Q and stack unchanged.
- increment: Q <= Q + 1 mod 2^WIDTH; all-ones wraps to 0, no flag.
- load: Q <= D; stack unchanged.
- call, stack not full: stack[sp] <= Q + 1 (mod 2^WIDTH), sp <= sp + 1, Q <= D.
- call, stack full: jump still taken (Q <= D), push suppressed, stack contents and sp unchanged, stack_err <= 1.
- ret, stack not empty: Q <= stack[sp-1], sp <= sp - 1.
- ret, stack empty: Q unchanged, sp unchanged, stack_err <= 1.
- call and ret together: ret wins, call ignored entirely (no push, no jump).
- load/increment asserted with call or ret: ignored.
- stack_err stays high until reset; it never blocks further operation.
- sp is a $clog2(STACK_DEPTH+1)-bit counter, range 0..STACK_DEPTH; stack_empty = (sp == 0), stack_full = (sp == STACK_DEPTH).
- LIFO order: last pushed entry returned first; no wrap-around of the stack pointer.

## Timing

- All outputs registered; every action visible on Q one cycle after the edge on which it is sampled.
- Flags reflect post-edge state in the same cycle as Q.
- Reset values: Q = RESET_VECTOR, sp = 0, stack_empty = 1, stack_full = 0, stack_err = 0. Stack entry contents are don't-care after reset.
- Reset asserted mid-sequence (e.g. during a call) overrides all controls on that edge; the pending push is discarded.
- Back-to-back call/ret on consecutive cycles supported at full rate; no bubbles.
- Combinational path from inputs to outputs: none.

## Configuration

- Macro PC_CALL_STACK_EN.
- Defined: return-address stack and call/ret behaviour as described above.
- Not defined: no stack storage generated; call acts as load (Q <= D, same priority slot); ret is ignored; stack_empty tied 1, stack_full tied 0, stack_err tied 0. Port list identical in both builds.

## Test plan

- Reset then increment for 3 cycles (WIDTH=11, RESET_VECTOR=0) -> Q = 0,1,2,3; stack_empty=1, stack_err=0.
- Load D=11'h7FF, then increment -> Q = 7FF, then 000 (wrap), no flag.
- Q=10, call D=100; at 100 call D=200; ret; ret -> Q = 100, 200, 101, 11; stack_empty=1 at end, stack_err=0.
- Four calls fill stack (stack_full=1), fifth call D=300 -> Q=300, stack_err=1, subsequent four rets return the first four return addresses in LIFO order.
- ret on empty stack at Q=50 -> Q stays 50, stack_err=1; assert reset -> Q=0, stack_err=0.
- call and ret asserted together with one entry (return addr 21), D=400 -> Q=21, stack_empty=1; without PC_CALL_STACK_EN, call D=400 -> Q=400, ret -> Q holds, flags constant.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC with increment, jump and a call/return stack.
// Define PC_CALL_STACK_EN to build the return-address stack; otherwise call acts as load.
module pc_sequencer #(
   parameter int WIDTH = 11,
   parameter int STACK_DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             increment,
   input  logic             load,
   input  logic [WIDTH-1:0] D,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] Q,
   output logic             stack_empty,
   output logic             stack_full,
   output logic             stack_err
);
   logic [WIDTH-1:0] q_q, q_d;
   assign Q = q_q;
`ifdef PC_CALL_STACK_EN
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   // Entry index width; at least one bit so a single-entry stack still has a valid address.
   localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   logic [WIDTH-1:0] stack_q [2**AW];
   logic [SPW-1:0]   sp_q, sp_d, sp_m1;
   logic             err_q, err_d, push;
   assign sp_m1       = sp_q - SPW'(1);
   assign stack_empty = (sp_q == '0);
   assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
   assign stack_err   = err_q;
   always_comb begin
      q_d  = q_q;
      sp_d = sp_q;
      err_d = err_q;
      push = 1'b0;
      if (ret) begin
         if (stack_empty) err_d = 1'b1;
         else begin
            q_d  = stack_q[sp_m1[AW-1:0]];
            sp_d = sp_m1;
         end
      end else if (call) begin
         q_d = D;
         if (stack_full) err_d = 1'b1;
         else begin
            push = 1'b1;
            sp_d = sp_q + SPW'(1);
         end
      end else if (load) q_d = D;
      else if (increment) q_d = q_q + WIDTH'(1);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q   <= RESET_VECTOR;
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push && !reset) stack_q[sp_q[AW-1:0]] <= q_q + WIDTH'(1);
   end
`else
   logic unused_ret;
   assign unused_ret  = ret;
   assign stack_empty = 1'b1;
   assign stack_full  = 1'b0;
   assign stack_err   = 1'b0;
   always_comb q_d = (call || load) ? D : increment ? q_q + WIDTH'(1) : q_q;
   always_ff @(posedge clk) begin
      if (reset) q_q <= RESET_VECTOR;
      else q_q <= q_d;
   end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus random stimulus against a queue-based PC/stack model.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1, increment = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0;
   logic [10:0] D = '0;
   logic [10:0] Q;
   logic        stack_empty, stack_full, stack_err;
   int          n_chk = 0, n_fail = 0;
   logic [10:0] m_q;
   logic [10:0] m_stk[$];
   logic        m_err;

   pc_sequencer #(.WIDTH(11), .STACK_DEPTH(4), .RESET_VECTOR(11'd0)) dut (
      .clk(clk), .reset(reset), .increment(increment), .load(load), .D(D),
      .call(call), .ret(ret), .Q(Q), .stack_empty(stack_empty),
      .stack_full(stack_full), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic inc, input logic ld,
                             input logic [10:0] d, input logic cl, input logic rt);
      if (r) begin
         m_q = 11'd0;
         m_stk.delete();
         m_err = 1'b0;
      end
`ifdef PC_CALL_STACK_EN
      else if (rt) begin
         if (m_stk.size() == 0) m_err = 1'b1;
         else m_q = m_stk.pop_back();
      end else if (cl) begin
         if (m_stk.size() == 4) m_err = 1'b1;
         else m_stk.push_back(m_q + 11'd1);
         m_q = d;
      end
`else
      else if (cl) m_q = d;
`endif
      else if (ld) m_q = d;
      else if (inc) m_q = m_q + 11'd1;
   endtask

   task automatic step(input logic r, input logic inc, input logic ld,
                       input logic [10:0] d, input logic cl, input logic rt);
      reset = r; increment = inc; load = ld; D = d; call = cl; ret = rt;
      @(posedge clk);
      model_step(r, inc, ld, d, cl, rt);
      #1;
      check("Q", 32'(Q), 32'(m_q));
`ifdef PC_CALL_STACK_EN
      check("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
      check("stack_full", 32'(stack_full), 32'(m_stk.size() == 4));
      check("stack_err", 32'(stack_err), 32'(m_err));
`else
      check("stack_empty", 32'(stack_empty), 32'd1);
      check("stack_full", 32'(stack_full), 32'd0);
      check("stack_err", 32'(stack_err), 32'd0);
`endif
   endtask

   initial begin
      m_q = 11'd0;
      m_err = 1'b0;
      step(1, 0, 0, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 11'h7FF, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 11'd10, 0, 0);
      step(0, 0, 0, 11'd100, 1, 0);
      step(0, 0, 0, 11'd200, 1, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 11'(50 * i + 100), 1, 0);
      repeat (4) step(0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 11'd50, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 11'd20, 0, 0);
      step(0, 0, 0, 11'd500, 1, 0);
      step(0, 1, 1, 11'd400, 1, 1);
      step(0, 0, 0, 11'd600, 1, 0);
      step(1, 0, 0, 11'd700, 1, 0);
      step(0, 0, 1, 11'd300, 0, 1);
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] r;
         r = $urandom;
         step(r[5:0] == 6'd0, r[6], r[7] & r[8], 11'($urandom),
              r[11:10] == 2'd0, r[13:12] == 2'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
